apb_blink_sequencer: RTL and testbench

APB-programmable sequencer that drives the blink-rate configuration of a downstream LED blinker. It steps through a table of up to eight (rate, toggle-count) entries. For each entry it loads a rate into the blinker, counts LED toggles reported back, then advances. It sits between the processor APB bus and the blinker's rate input, and supports one-shot and looping patterns.

---
 rtl/apb_blink_sequencer_if.sv | 29 ++
 rtl/apb_blink_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_apb_blink_sequencer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_blink_sequencer_if.sv
// ============================================================================
// Module      : apb_blink_sequencer_if
// Description : APB completer bus bundle for the blink sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_blink_sequencer_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        perr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, perr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, perr
    );
endinterface

`default_nettype wire

// File: rtl/apb_blink_sequencer.sv
// ============================================================================
// Module      : apb_blink_sequencer
// Description : APB-programmed table sequencer driving an LED blinker rate.
//               Optional macro BLINK_SEQ_PERR_EN enables perr on unmapped access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_blink_sequencer #(
    parameter int unsigned DEFAULT_RATE = 32'd100000000,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    apb_blink_sequencer_if.slave        apb,
    input  logic                        toggle_in,
    output logic [31:0]                 rate_out,
    output logic                        rate_load,
    output logic                        busy,
    output logic                        done_irq
);

    localparam logic [31:0] C_DEF_RATE = DEFAULT_RATE;
    localparam logic [3:0]  C_DEPTH    = 4'(DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic [15:0] r_tcnt, w_tcnt_nxt;
    logic [31:0] r_rate_out, w_rate_nxt;
    logic        r_rate_load, w_load_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_fin, w_fin_nxt;
    logic        w_done_set;
    logic        r_done, r_loop;
    logic [3:0]  r_len;
    logic [31:0] r_rate [DEPTH];
    logic [15:0] r_count [DEPTH];
    logic [31:0] r_prdata;
    logic        r_pready, r_perr;
    logic [15:0] w_cnt_lim;
    logic [16:0] w_tcnt_inc;

    // ------------------------------------------------------------ decode
    logic [7:0]  w_off;
    logic        w_acc, w_wr, w_aligned;
    logic        w_hit_ctrl, w_hit_stat, w_hit_len, w_rate_hit, w_cnt_hit, w_mapped;
    logic [2:0]  w_rate_idx, w_cnt_idx;
    logic        w_start, w_abort, w_clr;
    logic [31:0] w_rdata;
    logic [23:0] w_unused_addr;

    assign w_off         = apb.paddr[7:0];
    assign w_unused_addr = apb.paddr[31:8];
    assign w_acc         = apb.psel & apb.penable;
    assign w_wr          = w_acc & apb.pwrite;
    assign w_aligned     = (w_off[1:0] == 2'b00);
    assign w_hit_ctrl    = (w_off == 8'h00);
    assign w_hit_stat    = (w_off == 8'h04);
    assign w_hit_len     = (w_off == 8'h08);
    assign w_rate_idx    = 3'(w_off[5:2] - 4'd4);
    assign w_cnt_idx     = 3'(w_off[6:2] - 5'd12);
    assign w_rate_hit    = w_aligned && (w_off >= 8'h10) && (w_off < 8'h30)
                           && ({1'b0, w_rate_idx} < C_DEPTH);
    assign w_cnt_hit     = w_aligned && (w_off >= 8'h30) && (w_off < 8'h50)
                           && ({1'b0, w_cnt_idx} < C_DEPTH);
    assign w_mapped      = w_hit_ctrl | w_hit_stat | w_hit_len | w_rate_hit | w_cnt_hit;

    // Abort takes priority over start when both arrive in one write
    assign w_abort = w_wr & w_hit_ctrl & apb.pwdata[2];
    assign w_start = w_wr & w_hit_ctrl & apb.pwdata[0] & ~apb.pwdata[2];
    assign w_clr   = w_wr & w_hit_stat & apb.pwdata[1];

    always_comb begin
        w_rdata = '0;
        if (w_hit_ctrl)      w_rdata = {30'd0, r_loop, 1'b0};
        else if (w_hit_stat) w_rdata = {25'd0, r_idx, 2'b00, r_done, r_busy};
        else if (w_hit_len)  w_rdata = {28'd0, r_len};
        else if (w_rate_hit) w_rdata = r_rate[w_rate_idx];
        else if (w_cnt_hit)  w_rdata = {16'd0, r_count[w_cnt_idx]};
    end

    // ------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // r_fin marks the IDLE cycle that finishes a one-shot pass
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tcnt_nxt  = r_tcnt;
        w_rate_nxt  = r_rate_out;
        w_load_nxt  = 1'b0;
        w_busy_nxt  = r_busy;
        w_fin_nxt   = 1'b0;
        w_done_set  = 1'b0;
        w_cnt_lim   = (r_count[r_idx] == 16'd0) ? 16'd1 : r_count[r_idx];
        w_tcnt_inc  = {1'b0, r_tcnt} + 17'd1;
        if (w_abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_rate_nxt  = C_DEF_RATE;
            w_load_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_fin) begin
                        w_rate_nxt = C_DEF_RATE;
                        w_load_nxt = 1'b1;
                        w_busy_nxt = 1'b0;
                        w_done_set = 1'b1;
                    end else if (w_start && (r_len != 4'd0)) begin
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_rate_nxt  = r_rate[r_idx];
                    w_load_nxt  = 1'b1;
                    w_tcnt_nxt  = 16'd0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (toggle_in) begin
                        if (w_tcnt_inc >= {1'b0, w_cnt_lim}) begin
                            if (({1'b0, r_idx} + 4'd1) < r_len) begin
                                w_idx_nxt   = r_idx + 3'd1;
                                w_state_nxt = S_LOAD;
                            end else if (r_loop) begin
                                w_idx_nxt   = 3'd0;
                                w_state_nxt = S_LOAD;
                            end else begin
                                w_fin_nxt   = 1'b1;
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_tcnt_nxt = w_tcnt_inc[15:0];
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= 3'd0;
            r_tcnt      <= 16'd0;
            r_rate_out  <= C_DEF_RATE;
            r_rate_load <= 1'b0;
            r_busy      <= 1'b0;
            r_fin       <= 1'b0;
            r_done      <= 1'b0;
            r_loop      <= 1'b0;
            r_len       <= 4'd1;
            r_prdata    <= 32'd0;
            r_pready    <= 1'b0;
            r_perr      <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_rate[i]  <= C_DEF_RATE;
                r_count[i] <= 16'd1;
            end
        end else begin
            r_idx       <= w_idx_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_rate_out  <= w_rate_nxt;
            r_rate_load <= w_load_nxt;
            r_busy      <= w_busy_nxt;
            r_fin       <= w_fin_nxt;
            r_prdata    <= w_rdata;
            r_pready    <= 1'b1;
`ifdef BLINK_SEQ_PERR_EN
            r_perr      <= w_acc & ~w_mapped;
`else
            r_perr      <= 1'b0;
`endif
            if (w_done_set)  r_done <= 1'b1;
            else if (w_clr)  r_done <= 1'b0;
            if (w_wr && w_hit_ctrl) r_loop <= apb.pwdata[1];
            if (w_wr && w_hit_len)
                r_len <= (apb.pwdata > 32'(DEPTH)) ? C_DEPTH : apb.pwdata[3:0];
            if (w_wr && w_rate_hit) r_rate[w_rate_idx] <= apb.pwdata;
            if (w_wr && w_cnt_hit)  r_count[w_cnt_idx] <= apb.pwdata[15:0];
        end
    end

    assign apb.prdata = r_prdata;
    assign apb.pready = r_pready;
    assign apb.perr   = r_perr;
    assign rate_out   = r_rate_out;
    assign rate_load  = r_rate_load;
    assign busy       = r_busy;
    assign done_irq   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_apb_blink_sequencer.sv
// ============================================================================
// Module      : tb_apb_blink_sequencer
// Description : Self-checking bench; rate_load strobes checked against a queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_blink_sequencer;

    localparam logic [31:0] C_DEF = 32'd100000000;

    logic        clk;
    logic        rst_n;
    logic        toggle_in;
    logic [31:0] rate_out;
    logic        rate_load;
    logic        busy;
    logic        done_irq;

    int n_checks;
    int n_fail;
    logic [31:0] sb_q[$];

    apb_blink_sequencer_if bus ();

    apb_blink_sequencer #(
        .DEFAULT_RATE (C_DEF),
        .DEPTH        (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .apb       (bus),
        .toggle_in (toggle_in),
        .rate_out  (rate_out),
        .rate_load (rate_load),
        .busy      (busy),
        .done_irq  (done_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every rate_load strobe must match the next expected rate
    always @(negedge clk) begin
        if (rate_load === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_load: got rate %0d, expected no strobe", rate_out);
            end else begin
                logic [31:0] exp_rate;
                exp_rate = sb_q.pop_front();
                if (rate_out !== exp_rate) begin
                    n_fail++;
                    $display("FAIL sb_rate: got %0d, expected %0d", rate_out, exp_rate);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        bus.paddr   = a;
        bus.pwdata  = d;
        bus.pwrite  = 1'b1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        tick(1);
        bus.penable = 1'b1;
        tick(1);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        bus.paddr   = a;
        bus.pwrite  = 1'b0;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        tick(1);
        bus.penable = 1'b1;
        tick(1);
        d = bus.prdata;
        e = bus.perr;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic pulse_toggle();
        toggle_in = 1'b1;
        tick(1);
        toggle_in = 1'b0;
        tick(2);
    endtask

    task automatic load_table();
        apb_write(32'h08, 32'd2);
        apb_write(32'h10, 32'd10);
        apb_write(32'h30, 32'd2);
        apb_write(32'h14, 32'd20);
        apb_write(32'h34, 32'd1);
    endtask

    task automatic check_sb_empty(input string tag);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_sb_pending: got %0d outstanding strobes, expected 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        e;
        rst_n = 1'b0;
        tick(3);
        n_checks++;
        if (rate_out !== C_DEF || busy !== 1'b0 || done_irq !== 1'b0 || rate_load !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rate=%0d busy=%b done=%b load=%b, expected %0d 0 0 0",
                     rate_out, busy, done_irq, rate_load, C_DEF);
        end
        n_checks++;
        if (bus.pready !== 1'b0 || bus.prdata !== 32'd0 || bus.perr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus: got pready=%b prdata=%h perr=%b, expected 0 0 0",
                     bus.pready, bus.prdata, bus.perr);
        end
        rst_n = 1'b1;
        tick(1);
        n_checks++;
        if (bus.pready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pready: got %b, expected 1", bus.pready);
        end
        apb_read(32'h04, d, e);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_status: got %h, expected 0", d);
        end
        apb_read(32'h10, d, e);
        n_checks++;
        if (d !== C_DEF) begin
            n_fail++;
            $display("FAIL reset_rate0: got %0d, expected %0d", d, C_DEF);
        end
        apb_read(32'h30, d, e);
        n_checks++;
        if (d !== 32'd1) begin
            n_fail++;
            $display("FAIL reset_count0: got %0d, expected 1", d);
        end
    endtask

    task automatic test_sequence();
        logic [31:0] d;
        logic        e;
        load_table();
        sb_q.push_back(32'd10);
        apb_write(32'h00, 32'h1);
        n_checks++;
        if (rate_load !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_load_cycle: got load=%b busy=%b, expected 0 0", rate_load, busy);
        end
        tick(1);
        n_checks++;
        if (rate_load !== 1'b1 || rate_out !== 32'd10 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_first_load: got load=%b rate=%0d busy=%b, expected 1 10 1",
                     rate_load, rate_out, busy);
        end
        tick(2);
        pulse_toggle();
        n_checks++;
        if (rate_out !== 32'd10) begin
            n_fail++;
            $display("FAIL seq_hold_rate0: got %0d, expected 10", rate_out);
        end
        sb_q.push_back(32'd20);
        pulse_toggle();
        n_checks++;
        if (rate_out !== 32'd20) begin
            n_fail++;
            $display("FAIL seq_rate1: got %0d, expected 20", rate_out);
        end
        sb_q.push_back(C_DEF);
        pulse_toggle();
        tick(1);
        n_checks++;
        if (done_irq !== 1'b1 || busy !== 1'b0 || rate_out !== C_DEF) begin
            n_fail++;
            $display("FAIL seq_finish: got done=%b busy=%b rate=%0d, expected 1 0 %0d",
                     done_irq, busy, rate_out, C_DEF);
        end
        apb_read(32'h04, d, e);
        n_checks++;
        if (d[1:0] !== 2'b10) begin
            n_fail++;
            $display("FAIL seq_status: got %h, expected done=1 busy=0", d);
        end
        check_sb_empty("seq");
    endtask

    task automatic test_loop();
        logic [31:0] d;
        logic        e;
        apb_write(32'h04, 32'h2);
        n_checks++;
        if (done_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_w1c: got done=%b, expected 0", done_irq);
        end
        sb_q.push_back(32'd10);
        apb_write(32'h00, 32'h3);
        tick(3);
        pulse_toggle();
        sb_q.push_back(32'd20);
        pulse_toggle();
        sb_q.push_back(32'd10);
        pulse_toggle();
        tick(1);
        n_checks++;
        if (rate_out !== 32'd10 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_wrap_rate: got rate=%0d busy=%b, expected 10 1", rate_out, busy);
        end
        apb_read(32'h04, d, e);
        n_checks++;
        if (d !== 32'h01) begin
            n_fail++;
            $display("FAIL loop_status: got %h, expected 01", d);
        end
        sb_q.push_back(C_DEF);
        apb_write(32'h00, 32'h6);
        tick(1);
        n_checks++;
        if (rate_out !== C_DEF || done_irq !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_abort: got rate=%0d done=%b busy=%b, expected %0d 0 0",
                     rate_out, done_irq, busy, C_DEF);
        end
        apb_write(32'h00, 32'h0);
        check_sb_empty("loop");
    endtask

    task automatic test_len_start();
        logic [31:0] d;
        logic        e;
        apb_write(32'h08, 32'd12);
        apb_read(32'h08, d, e);
        n_checks++;
        if (d !== 32'd8) begin
            n_fail++;
            $display("FAIL len_clamp: got %0d, expected 8", d);
        end
        apb_write(32'h08, 32'd0);
        apb_write(32'h00, 32'h1);
        tick(4);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_start: got busy=%b, expected 0", busy);
        end
        apb_write(32'h08, 32'd2);
        sb_q.push_back(32'd10);
        apb_write(32'h00, 32'h1);
        tick(3);
        pulse_toggle();
        sb_q.push_back(32'd20);
        pulse_toggle();
        apb_write(32'h00, 32'h1);
        tick(3);
        apb_read(32'h04, d, e);
        n_checks++;
        if (d !== 32'h11 || rate_out !== 32'd20) begin
            n_fail++;
            $display("FAIL start_busy: got status=%h rate=%0d, expected 11 20", d, rate_out);
        end
        sb_q.push_back(C_DEF);
        apb_write(32'h00, 32'h4);
        tick(1);
        n_checks++;
        if (busy !== 1'b0 || done_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy_abort: got busy=%b done=%b, expected 0 0", busy, done_irq);
        end
        check_sb_empty("len");
    endtask

    task automatic test_done_w1c();
        apb_write(32'h08, 32'd1);
        apb_write(32'h30, 32'd1);
        sb_q.push_back(32'd10);
        apb_write(32'h00, 32'h1);
        tick(3);
        sb_q.push_back(C_DEF);
        bus.paddr   = 32'h04;
        bus.pwdata  = 32'h2;
        bus.pwrite  = 1'b1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        toggle_in   = 1'b1;
        tick(1);
        bus.penable = 1'b1;
        toggle_in   = 1'b0;
        tick(1);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        n_checks++;
        if (done_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL done_set_wins: got %b, expected 1", done_irq);
        end
        apb_write(32'h04, 32'h2);
        n_checks++;
        if (done_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL done_w1c: got %b, expected 0", done_irq);
        end
        check_sb_empty("w1c");
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d;
        logic        e;
        apb_write(32'h08, 32'd2);
        apb_write(32'h30, 32'd2);
        apb_write(32'h00, 32'h2);
        sb_q.push_back(32'd10);
        apb_write(32'h00, 32'h3);
        tick(3);
        pulse_toggle();
        rst_n = 1'b0;
        tick(1);
        n_checks++;
        if (rate_out !== C_DEF || rate_load !== 1'b0 || busy !== 1'b0 ||
            done_irq !== 1'b0 || bus.pready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: got rate=%0d load=%b busy=%b done=%b pready=%b, expected %0d 0 0 0 0",
                     rate_out, rate_load, busy, done_irq, bus.pready, C_DEF);
        end
        rst_n = 1'b1;
        tick(2);
        apb_read(32'h08, d, e);
        n_checks++;
        if (d !== 32'd1) begin
            n_fail++;
            $display("FAIL midrun_len: got %0d, expected 1", d);
        end
        apb_read(32'h10, d, e);
        n_checks++;
        if (d !== C_DEF) begin
            n_fail++;
            $display("FAIL midrun_rate0: got %0d, expected %0d", d, C_DEF);
        end
        apb_read(32'h00, d, e);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_ctrl: got %h, expected 0", d);
        end
        check_sb_empty("rst");
    endtask

    task automatic test_perr();
        logic [31:0] d;
        logic        e;
        logic        exp_e;
`ifdef BLINK_SEQ_PERR_EN
        exp_e = 1'b1;
`else
        exp_e = 1'b0;
`endif
        apb_read(32'h80, d, e);
        n_checks++;
        if (d !== 32'd0 || e !== exp_e) begin
            n_fail++;
            $display("FAIL perr_unmapped: got prdata=%h perr=%b, expected 0 %b", d, e, exp_e);
        end
        apb_read(32'h08, d, e);
        n_checks++;
        if (e !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_mapped: got perr=%b, expected 0", e);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        toggle_in   = 1'b0;
        bus.paddr   = 32'd0;
        bus.pwdata  = 32'd0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        test_reset();
        test_sequence();
        test_loop();
        test_len_start();
        test_done_w1c();
        test_reset_mid_run();
        test_perr();
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
